// File: rtl/tt_um_seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Results are held until the next completion; divide-by-zero is flagged and keeps full latency.
module tt_um_seq_divider #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  dbz
);

  localparam int unsigned CntW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0]   shreg_q, shreg_d;
  logic [DIVISOR_W-1:0]    divisor_q, divisor_d;
  logic [DIVISOR_W-1:0]    p_q, p_d;
  logic [DIVIDEND_W-1:0]   quot_q, quot_d;
  logic [DIVISOR_W-1:0]    rem_q, rem_d;
  logic                    dbz_q, dbz_d;

  logic [DIVISOR_W:0]      t;
  logic [DIVISOR_W-1:0]    diff;
  logic                    ge;

  // The partial remainder is always below the divisor after a step, so its top bit need not
  // be stored; the low-bit subtract is exact whenever the compare succeeds.
  always_comb begin
    t    = {p_q, shreg_q[DIVIDEND_W-1]};
    ge   = (t >= {1'b0, divisor_q});
    diff = t[DIVISOR_W-1:0] - divisor_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    divisor_d = divisor_q;
    p_d       = p_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          state_d   = StRun;
          cnt_d     = CntW'(DIVIDEND_W - 1);
          shreg_d   = dividend;
          divisor_d = divisor;
          p_d       = '0;
        end
      end
      StRun: begin
        p_d     = ge ? diff : t[DIVISOR_W-1:0];
        shreg_d = {shreg_q[DIVIDEND_W-2:0], ge};
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // A zero divisor makes every compare succeed, which naturally yields an all-ones
          // quotient and the dividend's low bits as remainder.
          state_d = StDone;
          quot_d  = shreg_d;
          rem_d   = p_d;
          dbz_d   = (divisor_q == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      divisor_q <= '0;
      p_q       <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      divisor_q <= divisor_d;
      p_q       <= p_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_tt_um_seq_divider.sv
// Directed and randomised checks of tt_um_seq_divider: latency, handshake, dbz, abort, back-to-back.
module tb_tt_um_seq_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy, done, dbz;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  int vectors = 0;
  int miscompares = 0;

  tt_um_seq_divider #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  // Issues one request from a point just after an edge; returns edges from accept to done (-1 on timeout).
  task automatic run_div(input logic [15:0] a, input logic [7:0] b, output int lat);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, quotient, remainder, dbz} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dbz=%b, expected all 0",
               busy, done, quotient, remainder, dbz);
    end
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    run_div(16'd1000, 8'd7, lat);
    vectors++;
    if (lat !== 16) begin
      miscompares++; $display("FAIL basic_latency: got %0d, expected 16", lat);
    end
    vectors++;
    if ({quotient, remainder, dbz} !== {16'd142, 8'd6, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_1000_7: got q=%0d r=%0d dbz=%b, expected q=142 r=6 dbz=0",
               quotient, remainder, dbz);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || quotient !== 16'd142) begin
      miscompares++;
      $display("FAIL done_pulse_hold: got done=%b q=%0d, expected done=0 q=142", done, quotient);
    end
  endtask

  task automatic test_edges();
    logic [15:0] a_t [3]  = '{16'hFFFF, 16'hFFFF, 16'd100};
    logic [7:0]  b_t [3]  = '{8'h01, 8'hFF, 8'd200};
    logic [15:0] q_t [3]  = '{16'hFFFF, 16'h0101, 16'd0};
    logic [7:0]  r_t [3]  = '{8'd0, 8'd0, 8'd100};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_div(a_t[i], b_t[i], lat);
      vectors++;
      if (lat !== 16 || quotient !== q_t[i] || remainder !== r_t[i] || dbz !== 1'b0) begin
        miscompares++;
        $display("FAIL edge_%0d: got lat=%0d q=%h r=%h dbz=%b, expected lat=16 q=%h r=%h dbz=0",
                 i, lat, quotient, remainder, dbz, q_t[i], r_t[i]);
      end
    end
  endtask

  task automatic test_dbz();
    int lat;
    run_div(16'h1234, 8'h00, lat);
    vectors++;
    if (lat !== 16 || quotient !== 16'hFFFF || remainder !== 8'h34 || dbz !== 1'b1) begin
      miscompares++;
      $display("FAIL dbz: got lat=%0d q=%h r=%h dbz=%b, expected lat=16 q=ffff r=34 dbz=1",
               lat, quotient, remainder, dbz);
    end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    int bad_busy = 0;
    int bad_hold = 0;
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 3) begin start = 1'b1; dividend = 16'd50; divisor = 8'd5; end
      if (i == 4) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
      if (busy !== 1'b1) bad_busy++;
      if (quotient !== 16'hFFFF || dbz !== 1'b1) bad_hold++;
    end
    start = 1'b0;
    vectors++;
    if (bad_busy != 0) begin
      miscompares++; $display("FAIL busy_during_run: got %0d low cycles, expected 0", bad_busy);
    end
    vectors++;
    if (bad_hold != 0) begin
      miscompares++;
      $display("FAIL hold_during_run: got %0d changed cycles, expected 0", bad_hold);
    end
    vectors++;
    if (lat !== 16 || quotient !== 16'd142 || remainder !== 8'd6 || dbz !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d dbz=%b, expected lat=16 q=142 r=6 dbz=0",
               lat, quotient, remainder, dbz);
    end
  endtask

  task automatic test_abort();
    int lat;
    int saw_done = 0;
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if ({busy, done, quotient, remainder, dbz} !== 27'd0) begin
      miscompares++;
      $display("FAIL abort_outputs: got busy=%b done=%b q=%h r=%h dbz=%b, expected all 0",
               busy, done, quotient, remainder, dbz);
    end
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done++;
    end
    vectors++;
    if (saw_done != 0) begin
      miscompares++; $display("FAIL abort_no_done: got %0d active cycles, expected 0", saw_done);
    end
    run_div(16'd81, 8'd9, lat);
    vectors++;
    if (lat !== 16 || quotient !== 16'd9 || remainder !== 8'd0) begin
      miscompares++;
      $display("FAIL after_abort_81_9: got lat=%0d q=%0d r=%0d, expected lat=16 q=9 r=0",
               lat, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_div(16'd1000, 8'd7, lat);
    start = 1'b1; dividend = 16'd300; divisor = 8'd10;
    vectors++;
    if (lat !== 16 || done !== 1'b1 || quotient !== 16'd142 || remainder !== 8'd6) begin
      miscompares++;
      $display("FAIL b2b_first: got lat=%0d done=%b q=%0d r=%0d, expected lat=16 done=1 q=142 r=6",
               lat, done, quotient, remainder);
    end
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: got busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    vectors++;
    if (lat !== 16 || quotient !== 16'd30 || remainder !== 8'd0) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d, expected lat=16 q=30 r=0",
               lat, quotient, remainder);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, eq;
    logic [7:0]  b, er;
    logic        ez;
    int lat;
    for (int n = 0; n < 2000; n++) begin
      a = 16'($urandom);
      b = (n % 50 == 0) ? 8'd0 : 8'($urandom);
      if (b == 0) begin eq = 16'hFFFF; er = a[7:0]; ez = 1'b1; end
      else begin eq = a / {8'd0, b}; er = 8'(a % {8'd0, b}); ez = 1'b0; end
      run_div(a, b, lat);
      vectors++;
      if (lat !== 16 || quotient !== eq || remainder !== er || dbz !== ez) begin
        miscompares++;
        $display("FAIL random %h/%h: got lat=%0d q=%h r=%h dbz=%b, expected lat=16 q=%h r=%h dbz=%b",
                 a, b, lat, quotient, remainder, dbz, eq, er, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_dbz();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
